// File: rtl/sfx_voice_arbiter_if.sv
// Bus between the sound-effect requesters and the pulse-voice arbiter.
// Signals:
//   tick, en                        synth tick strobe and arbiter enable
//   req, req_note, req_oct, req_len level requests and per-requester parameters
//   grant, voice_trigger            one-cycle acknowledge / oscillator retrigger
//   owner, voice_active             current owner index and busy flag
//   voice_note, voice_octave,
//   voice_vol                       latched voice parameters and attenuation
//   done, done_id, done_aborted     end-of-ownership report
// Modports: master = effect-logic side, slave = arbiter side.
interface sfx_voice_arbiter_if #(
  parameter int NREQ = 4,
  parameter int LENW = 5
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                 tick;
  logic                 en;
  logic [NREQ-1:0]      req;
  logic [3*NREQ-1:0]    req_note;
  logic [NREQ-1:0]      req_oct;
  logic [LENW*NREQ-1:0] req_len;
  logic [NREQ-1:0]      grant;
  logic [OW-1:0]        owner;
  logic                 voice_active;
  logic [2:0]           voice_note;
  logic                 voice_octave;
  logic [3:0]           voice_vol;
  logic                 voice_trigger;
  logic                 done;
  logic [OW-1:0]        done_id;
  logic                 done_aborted;

  modport master (
    output tick, en, req, req_note, req_oct, req_len,
    input  grant, owner, voice_active, voice_note, voice_octave, voice_vol,
           voice_trigger, done, done_id, done_aborted
  );

  modport slave (
    input  tick, en, req, req_note, req_oct, req_len,
    output grant, owner, voice_active, voice_note, voice_octave, voice_vol,
           voice_trigger, done, done_id, done_aborted
  );
endinterface

// File: rtl/sfx_voice_arbiter.sv
// Fixed-priority arbiter for the single pulse voice. The highest-index
// requester wins, its note/octave/length are latched, and a play/release
// attenuation envelope is stepped on the synth tick strobe.
// Ports:
//   clk48  system clock
//   rst_n  asynchronous active-low reset
//   bus    sfx_voice_arbiter_if.slave (requests in, voice/grant/done out)
module sfx_voice_arbiter #(
  parameter int NREQ    = 4,
  parameter int LENW    = 5,
  parameter int REL_DIV = 1
) (
  input  logic                   clk48,
  input  logic                   rst_n,
  sfx_voice_arbiter_if.slave     bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [OW-1:0]   owner_q;
  logic            active_q;
  logic [2:0]      note_q;
  logic            oct_q;
  logic [3:0]      vol_q;
  logic            trig_q;
  logic            done_q;
  logic [OW-1:0]   done_id_q;
  logic            done_ab_q;
  logic [LENW-1:0] rem_q;
  logic [3:0]      reldiv_q;

  logic [NREQ-1:0] own_mask;
  logic [NREQ-1:0] cand;
  logic            any;
  logic [OW-1:0]   win;
  logic [LENW-1:0] win_len;
  logic [2:0]      win_note;
  logic            win_oct;

  // Highest set index wins.
  function automatic logic [OW-1:0] pick_hi(input logic [NREQ-1:0] r);
    pick_hi = '0;
    for (int i = 0; i < NREQ; i++)
      if (r[i]) pick_hi = OW'(i);
  endfunction

  // The current owner must not re-win (or preempt itself) while it holds the voice.
  always_comb begin
    own_mask = '0;
    if (state_q != IDLE) own_mask[owner_q] = 1'b1;
  end

  assign cand = bus.en ? (bus.req & ~own_mask) : '0;
  assign any  = |cand;
  assign win  = pick_hi(cand);

  always_comb begin
    win_len  = '0;
    win_note = '0;
    win_oct  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (OW'(i) == win) begin
        win_len  = bus.req_len[LENW*i +: LENW];
        win_note = bus.req_note[3*i +: 3];
        win_oct  = bus.req_oct[i];
      end
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      active_q  <= 1'b0;
      note_q    <= '0;
      oct_q     <= 1'b0;
      vol_q     <= 4'd15;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      done_ab_q <= 1'b0;
      rem_q     <= '0;
      reldiv_q  <= '0;
    end else begin
      grant_q <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      if (state_q != IDLE && !bus.en) begin
        // Disable aborts the current ownership immediately.
        state_q   <= IDLE;
        active_q  <= 1'b0;
        vol_q     <= 4'd15;
        done_q    <= 1'b1;
        done_id_q <= owner_q;
        done_ab_q <= 1'b1;
      end else if (any && (state_q == IDLE || win > owner_q)) begin
        // New grant or preemption; a coincident tick is deliberately dropped.
        if (state_q != IDLE) begin
          done_q    <= 1'b1;
          done_id_q <= owner_q;
          done_ab_q <= 1'b1;
        end
        grant_q        <= '0;
        grant_q[win]   <= 1'b1;
        trig_q         <= 1'b1;
        owner_q        <= win;
        note_q         <= win_note;
        oct_q          <= win_oct;
        rem_q          <= (win_len == '0) ? LENW'(1) : win_len;
        vol_q          <= 4'd0;
        state_q        <= PLAY;
        active_q       <= 1'b1;
      end else if (bus.tick) begin
        case (state_q)
          PLAY: begin
            rem_q <= rem_q - LENW'(1);
            if (rem_q == LENW'(1)) begin
              state_q  <= RELEASE;
              reldiv_q <= '0;
            end
          end
          RELEASE: begin
            if (reldiv_q == 4'(REL_DIV - 1)) begin
              reldiv_q <= '0;
              vol_q    <= vol_q + 4'd1;
              // Reaching full attenuation is the natural end of the ownership.
              if (vol_q == 4'd14) begin
                state_q   <= IDLE;
                active_q  <= 1'b0;
                done_q    <= 1'b1;
                done_id_q <= owner_q;
                done_ab_q <= 1'b0;
              end
            end else begin
              reldiv_q <= reldiv_q + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.grant         = grant_q;
  assign bus.owner         = owner_q;
  assign bus.voice_active  = active_q;
  assign bus.voice_note    = note_q;
  assign bus.voice_octave  = oct_q;
  assign bus.voice_vol     = vol_q;
  assign bus.voice_trigger = trig_q;
  assign bus.done          = done_q;
  assign bus.done_id       = done_id_q;
  assign bus.done_aborted  = done_ab_q;
endmodule

// File: tb/tb_sfx_voice_arbiter.sv
// Scoreboard bench: stimulus pushes the expected grant/done events (with the
// tick index at which they must appear); a negedge monitor pops and compares
// whenever a DUT shows grant or done. dut1 uses REL_DIV=1, dut2 REL_DIV=2.
module tb_sfx_voice_arbiter;
  logic clk48 = 1'b0;
  logic rst_n;
  always #5 clk48 = ~clk48;

  sfx_voice_arbiter_if #(.NREQ(4), .LENW(5)) b ();
  sfx_voice_arbiter_if #(.NREQ(4), .LENW(5)) b2 ();

  sfx_voice_arbiter #(.NREQ(4), .LENW(5), .REL_DIV(1)) dut1 (
    .clk48(clk48), .rst_n(rst_n), .bus(b));
  sfx_voice_arbiter #(.NREQ(4), .LENW(5), .REL_DIV(2)) dut2 (
    .clk48(clk48), .rst_n(rst_n), .bus(b2));

  assign b2.tick = b.tick;
  assign b2.en   = b.en;

  typedef struct {
    logic [3:0] grant;
    logic       done;
    logic [1:0] did;
    logic       dab;
    logic [1:0] owner;
    logic [2:0] note;
    logic       oct;
    logic [3:0] vol;
    int         tk;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];
  int  tcnt = 0;
  int  nchk = 0;
  int  nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic [3:0] g, input logic d, input logic [1:0] di,
                             input logic da, input logic [1:0] ow, input logic [2:0] nt,
                             input logic oc, input logic [3:0] vl, input int tk);
    ev_t e;
    e.grant = g; e.done = d; e.did = di; e.dab = da; e.owner = ow;
    e.note = nt; e.oct = oc; e.vol = vl; e.tk = tk;
    return e;
  endfunction

  task automatic cmp(input string tag, input ev_t e, input logic [3:0] g, input logic d,
                     input logic [1:0] di, input logic da, input logic [1:0] ow,
                     input logic [2:0] nt, input logic oc, input logic [3:0] vl,
                     input logic tr);
    chk({tag, "_grant"}, g, e.grant);
    chk({tag, "_trigger"}, tr, (e.grant != 0));
    chk({tag, "_done"}, d, e.done);
    if (e.done) begin
      chk({tag, "_done_id"}, di, e.did);
      chk({tag, "_done_aborted"}, da, e.dab);
    end
    chk({tag, "_owner"}, ow, e.owner);
    chk({tag, "_note"}, nt, e.note);
    chk({tag, "_oct"}, oc, e.oct);
    chk({tag, "_vol"}, vl, e.vol);
    chk({tag, "_tick_index"}, tcnt, e.tk);
  endtask

  // Monitor: one block so the tick counter update is ordered after both compares.
  always @(negedge clk48) begin
    if (b.grant != 0 || b.done) begin
      if (q1.size() == 0) chk("dut1_unexpected_event", 1, 0);
      else cmp("dut1", q1.pop_front(), b.grant, b.done, b.done_id, b.done_aborted,
               b.owner, b.voice_note, b.voice_octave, b.voice_vol, b.voice_trigger);
    end
    if (b2.grant != 0 || b2.done) begin
      if (q2.size() == 0) chk("dut2_unexpected_event", 1, 0);
      else cmp("dut2", q2.pop_front(), b2.grant, b2.done, b2.done_id, b2.done_aborted,
               b2.owner, b2.voice_note, b2.voice_octave, b2.voice_vol, b2.voice_trigger);
    end
    if (b.tick) tcnt++;
  end

  task automatic nxt();
    @(posedge clk48); #1;
  endtask

  // Each tick strobe is one cycle high followed by one cycle low.
  task automatic tick_n(input int n);
    repeat (n) begin
      b.tick = 1'b1;
      nxt();
      b.tick = 1'b0;
      nxt();
    end
  endtask

  task automatic setr(input int i, input int nt, input int oc, input int ln);
    b.req_note[3*i +: 3] = 3'(nt);
    b.req_oct[i]         = 1'(oc);
    b.req_len[5*i +: 5]  = 5'(ln);
    b.req[i]             = 1'b1;
  endtask

  int t;

  initial begin
    rst_n = 1'b0;
    b.tick = 1'b0; b.en = 1'b1; b.req = '0; b.req_note = '0; b.req_oct = '0; b.req_len = '0;
    b2.req = '0; b2.req_note = '0; b2.req_oct = '0; b2.req_len = '0;
    repeat (3) @(posedge clk48);
    #1;
    chk("rst_vol", b.voice_vol, 15);
    chk("rst_active", b.voice_active, 0);
    chk("rst_grant", b.grant, 0);
    chk("rst_owner", b.owner, 0);
    chk("rst_done", b.done, 0);
    rst_n = 1'b1;
    nxt();

    // Single request, len 3, REL_DIV 1: done on the 18th tick.
    t = tcnt;
    setr(1, 5, 1, 3);
    q1.push_back(mk(4'b0010, 0, 0, 0, 1, 5, 1, 0, t));
    q1.push_back(mk(4'b0000, 1, 1, 0, 1, 5, 1, 15, t + 18));
    nxt();
    b.req = '0;
    chk("t1_active", b.voice_active, 1);
    tick_n(3);
    chk("t1_vol_after_play", b.voice_vol, 0);
    tick_n(10);
    chk("t1_vol_mid_release", b.voice_vol, 10);
    tick_n(5);
    chk("t1_idle", b.voice_active, 0);
    chk("t1_note_hold", b.voice_note, 5);
    repeat (2) nxt();

    // Simultaneous req0/req2; req0 held until served after owner 2 ends.
    t = tcnt;
    setr(0, 1, 0, 1);
    setr(2, 6, 1, 2);
    q1.push_back(mk(4'b0100, 0, 0, 0, 2, 6, 1, 0, t));
    q1.push_back(mk(4'b0000, 1, 2, 0, 2, 6, 1, 15, t + 17));
    q1.push_back(mk(4'b0001, 0, 0, 0, 0, 1, 0, 0, t + 17));
    q1.push_back(mk(4'b0000, 1, 0, 0, 0, 1, 0, 15, t + 33));
    nxt();
    b.req[2] = 1'b0;
    chk("t2_owner2", b.owner, 2);
    tick_n(17);
    b.req[0] = 1'b0;
    chk("t2_owner0", b.owner, 0);
    tick_n(16);
    repeat (2) nxt();

    // Preemption of owner 1 by requester 3 while in PLAY.
    t = tcnt;
    setr(1, 2, 0, 5);
    q1.push_back(mk(4'b0010, 0, 0, 0, 1, 2, 0, 0, t));
    nxt();
    b.req = '0;
    tick_n(2);
    setr(3, 7, 1, 4);
    q1.push_back(mk(4'b1000, 1, 1, 1, 3, 7, 1, 0, t + 2));
    q1.push_back(mk(4'b0000, 1, 3, 0, 3, 7, 1, 15, t + 21));
    nxt();
    b.req = '0;
    chk("t3_owner", b.owner, 3);
    chk("t3_vol", b.voice_vol, 0);
    tick_n(19);
    chk("t3_idle", b.voice_active, 0);
    repeat (2) nxt();

    // Lower-priority request during ownership waits for the natural end.
    t = tcnt;
    setr(2, 3, 0, 1);
    q1.push_back(mk(4'b0100, 0, 0, 0, 2, 3, 0, 0, t));
    nxt();
    b.req = '0;
    tick_n(1);
    setr(0, 4, 1, 2);
    q1.push_back(mk(4'b0000, 1, 2, 0, 2, 3, 0, 15, t + 16));
    q1.push_back(mk(4'b0001, 0, 0, 0, 0, 4, 1, 0, t + 16));
    q1.push_back(mk(4'b0000, 1, 0, 0, 0, 4, 1, 15, t + 33));
    tick_n(14);
    chk("t4_owner_kept", b.owner, 2);
    chk("t4_vol", b.voice_vol, 14);
    tick_n(1);
    b.req = '0;
    tick_n(17);
    repeat (2) nxt();

    // Disable in RELEASE at vol 7, with the request still held.
    t = tcnt;
    setr(0, 0, 0, 2);
    q1.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, t));
    nxt();
    tick_n(9);
    chk("t6_vol7", b.voice_vol, 7);
    b.en = 1'b0;
    q1.push_back(mk(4'b0000, 1, 0, 1, 0, 0, 0, 15, t + 9));
    nxt();
    chk("t6_vol_mute", b.voice_vol, 15);
    tick_n(2);
    repeat (3) nxt();
    chk("t6_no_grant_disabled", b.voice_active, 0);
    b.req = '0;
    b.en = 1'b1;
    nxt();

    // Request and tick in the same cycle: the tick is not applied.
    t = tcnt;
    setr(2, 5, 0, 2);
    b.tick = 1'b1;
    q1.push_back(mk(4'b0100, 0, 0, 0, 2, 5, 0, 0, t + 1));
    q1.push_back(mk(4'b0000, 1, 2, 0, 2, 5, 0, 15, t + 18));
    nxt();
    b.tick = 1'b0;
    b.req = '0;
    nxt();
    tick_n(2);
    chk("t7_vol_still0", b.voice_vol, 0);
    tick_n(15);
    repeat (2) nxt();

    // len 0 with REL_DIV 2: one PLAY tick, 30 release ticks.
    t = tcnt;
    b2.req_note[2:0] = 3'd4;
    b2.req_oct[0] = 1'b1;
    b2.req_len[4:0] = 5'd0;
    b2.req[0] = 1'b1;
    q2.push_back(mk(4'b0001, 0, 0, 0, 0, 4, 1, 0, t));
    q2.push_back(mk(4'b0000, 1, 0, 0, 0, 4, 1, 15, t + 31));
    nxt();
    b2.req = '0;
    tick_n(3);
    chk("t5_vol_step", b2.voice_vol, 1);
    tick_n(28);
    chk("t5_idle", b2.voice_active, 0);
    repeat (2) nxt();

    // Asynchronous reset mid-play.
    t = tcnt;
    setr(3, 6, 1, 8);
    q1.push_back(mk(4'b1000, 0, 0, 0, 3, 6, 1, 0, t));
    nxt();
    b.req = '0;
    tick_n(3);
    rst_n = 1'b0;
    #1;
    chk("t8_vol", b.voice_vol, 15);
    chk("t8_active", b.voice_active, 0);
    chk("t8_owner", b.owner, 0);
    chk("t8_note", b.voice_note, 0);
    chk("t8_oct", b.voice_octave, 0);
    nxt();
    rst_n = 1'b1;
    repeat (5) nxt();

    chk("q1_pending_events", q1.size(), 0);
    chk("q2_pending_events", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
